// File: rtl/game_pkg.sv
// Shared definitions for the game timing block and the renderer: phase
// encodings, default rates/periods and the obstacle-period helper.
package game_pkg;

  localparam logic [2:0] PH_IDLE      = 3'd0;
  localparam logic [2:0] PH_COUNTDOWN = 3'd1;
  localparam logic [2:0] PH_RUN       = 3'd2;
  localparam logic [2:0] PH_PAUSE     = 3'd3;
  localparam logic [2:0] PH_OVER      = 3'd4;

  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_BASE_HZ   = 1000;
  localparam int DEF_OBST_BASE = 500;
  localparam int DEF_OBST_STEP = 40;
  localparam int DEF_OBST_MIN  = 100;
  localparam int DEF_ANIM_PER  = 100;
  localparam int DEF_SEC_PER   = 1000;
  localparam int DEF_CD_START  = 3;

  // Obstacle period in base ticks; 32-bit math so the subtraction cannot wrap.
  function automatic int obst_period(input int lvl, input int base,
                                     input int step, input int pmin);
    int drop;
    drop = lvl * step;
    if (drop >= base - pmin) return pmin;
    return base - drop;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// Reloadable down-counter: fires when it is at zero and enabled, then
// reloads; i_clear restarts the period from the reload value.
module tick_channel #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_reload,
  output logic         o_fire
);

  logic [W-1:0] r_cnt;

  assign o_fire = i_enable && (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_fire) begin
      r_cnt <= i_reload;
    end else if (i_enable) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timing controller: shared base-tick prescaler, three derived tick
// channels and the IDLE/COUNTDOWN/RUN/PAUSE/OVER phase machine.
module game_tick_scheduler
  import game_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BASE_HZ   = DEF_BASE_HZ,
  parameter int OBST_BASE = DEF_OBST_BASE,
  parameter int OBST_STEP = DEF_OBST_STEP,
  parameter int OBST_MIN  = DEF_OBST_MIN,
  parameter int ANIM_PER  = DEF_ANIM_PER,
  parameter int SEC_PER   = DEF_SEC_PER,
  parameter int CD_START  = DEF_CD_START,
  parameter int LEVEL_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause_toggle,
  input  logic               game_over,
  input  logic [LEVEL_W-1:0] level,
  output logic               base_tick,
  output logic               obst_tick,
  output logic               anim_tick,
  output logic               sec_tick,
  output logic [1:0]         countdown,
  output logic [2:0]         phase,
  output logic               running
);

  localparam int DIV      = CLK_HZ / BASE_HZ;
  localparam int PW       = cnt_width(DIV - 1);
  localparam int OBST_MAX = (OBST_BASE > OBST_MIN) ? OBST_BASE : OBST_MIN;
  localparam int OW       = cnt_width(OBST_MAX - 1);
  localparam int AW       = cnt_width(ANIM_PER - 1);
  localparam int SW       = cnt_width(SEC_PER - 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [2:0]    r_phase;
  logic [1:0]    r_countdown;
  logic [PW-1:0] r_presc;
  logic          r_base_tick;
  logic          r_obst_tick;
  logic          r_anim_tick;
  logic          r_sec_tick;

  logic          w_active;
  logic          w_go;
  logic          w_toggle;
  logic          w_start;
  logic          w_leave;
  logic          w_advance;
  logic          w_base_fire;
  logic          w_run_fire;
  logic          w_obst_fire;
  logic          w_anim_fire;
  logic          w_sec_fire;
  logic [OW-1:0] w_obst_reload;

  // Event decode with priority game_over > pause_toggle > start.
  assign w_active  = (r_phase == PH_COUNTDOWN) || (r_phase == PH_RUN);
  assign w_go      = game_over && (w_active || (r_phase == PH_PAUSE));
  assign w_toggle  = pause_toggle && !game_over &&
                     ((r_phase == PH_RUN) || (r_phase == PH_PAUSE));
  assign w_start   = start && ((r_phase == PH_IDLE) || (r_phase == PH_OVER));

  // Counting freezes in the cycle that leaves an active phase, which both
  // suppresses any tick due then and preserves the count across a pause.
  assign w_leave     = w_go || (w_toggle && (r_phase == PH_RUN));
  assign w_advance   = w_active && !w_leave;
  assign w_base_fire = w_advance && (r_presc == LAST);
  assign w_run_fire  = w_base_fire && (r_phase == PH_RUN);

  assign w_obst_reload = OW'(obst_period(int'(level), OBST_BASE, OBST_STEP, OBST_MIN) - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_start || !(w_active || (r_phase == PH_PAUSE))) begin
      r_presc <= '0;
    end else if (w_advance) begin
      r_presc <= (r_presc == LAST) ? '0 : r_presc + PW'(1);
    end
  end

  tick_channel #(.W(OW)) u_obst (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_enable (w_run_fire),
    .i_reload (w_obst_reload),
    .o_fire   (w_obst_fire)
  );

  tick_channel #(.W(AW)) u_anim (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_enable (w_run_fire),
    .i_reload (AW'(ANIM_PER - 1)),
    .o_fire   (w_anim_fire)
  );

  tick_channel #(.W(SW)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_enable (w_base_fire),
    .i_reload (SW'(SEC_PER - 1)),
    .o_fire   (w_sec_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base_tick <= 1'b0;
      r_obst_tick <= 1'b0;
      r_anim_tick <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_base_tick <= w_base_fire;
      r_obst_tick <= w_obst_fire;
      r_anim_tick <= w_anim_fire;
      r_sec_tick  <= w_sec_fire;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= PH_IDLE;
      r_countdown <= 2'd0;
    end else begin
      case (r_phase)
        PH_IDLE, PH_OVER: begin
          if (w_start) begin
            r_phase     <= PH_COUNTDOWN;
            r_countdown <= 2'(CD_START);
          end
        end
        PH_COUNTDOWN: begin
          if (w_go) begin
            r_phase     <= PH_OVER;
            r_countdown <= 2'd0;
          end else if (w_sec_fire) begin
            if (r_countdown == 2'd1) begin
              r_phase     <= PH_RUN;
              r_countdown <= 2'd0;
            end else begin
              r_countdown <= r_countdown - 2'd1;
            end
          end
        end
        PH_RUN: begin
          if (w_go)          r_phase <= PH_OVER;
          else if (w_toggle) r_phase <= PH_PAUSE;
        end
        PH_PAUSE: begin
          if (w_go)          r_phase <= PH_OVER;
          else if (w_toggle) r_phase <= PH_RUN;
        end
        default: begin
          r_phase     <= PH_IDLE;
          r_countdown <= 2'd0;
        end
      endcase
    end
  end

  assign base_tick = r_base_tick;
  assign obst_tick = r_obst_tick;
  assign anim_tick = r_anim_tick;
  assign sec_tick  = r_sec_tick;
  assign countdown = r_countdown;
  assign phase     = r_phase;
  assign running   = (r_phase == PH_RUN);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a per-stream scoreboard of
// expected tick cycles (DIV=10, SEC_PER=10, ANIM_PER=3, obstacle 8/2/4).
module tb_game_tick_scheduler;
  import game_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause_toggle;
  logic       game_over;
  logic [3:0] level;
  logic       base_tick;
  logic       obst_tick;
  logic       anim_tick;
  logic       sec_tick;
  logic [1:0] countdown;
  logic [2:0] phase;
  logic       running;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int q_exp [4][$];  // 0 base, 1 obst, 2 anim, 3 sec: expected pulse cycles

  game_tick_scheduler #(
    .CLK_HZ(100), .BASE_HZ(10), .OBST_BASE(8), .OBST_STEP(2), .OBST_MIN(4),
    .ANIM_PER(3), .SEC_PER(10), .CD_START(3), .LEVEL_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause_toggle (pause_toggle),
    .game_over    (game_over),
    .level        (level),
    .base_tick    (base_tick),
    .obst_tick    (obst_tick),
    .anim_tick    (anim_tick),
    .sec_tick     (sec_tick),
    .countdown    (countdown),
    .phase        (phase),
    .running      (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic sched(input int s, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) q_exp[s].push_back(c);
  endtask

  task automatic check_stream(input int s, input logic pulse, input string tag);
    logic due;
    due = (q_exp[s].size() > 0) && (q_exp[s][0] == cyc);
    if (due) void'(q_exp[s].pop_front());
    if (pulse !== 1'b0 || due) begin
      vectors++;
      assert (pulse === due) else begin
        miscompares++;
        $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, pulse, due);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_stream(0, base_tick, "base_tick");
    check_stream(1, obst_tick, "obst_tick");
    check_stream(2, anim_tick, "anim_tick");
    check_stream(3, sec_tick,  "sec_tick");
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_state(input string tag, input logic [2:0] ph, input logic [1:0] cd);
    vectors++;
    assert (phase === ph) else begin
      miscompares++;
      $error("FAIL %s phase: observed %0d expected %0d", tag, phase, ph);
    end
    vectors++;
    assert (countdown === cd) else begin
      miscompares++;
      $error("FAIL %s countdown: observed %0d expected %0d", tag, countdown, cd);
    end
    vectors++;
    assert (running === (ph == PH_RUN)) else begin
      miscompares++;
      $error("FAIL %s running: observed %b expected %b", tag, running, ph == PH_RUN);
    end
  endtask

  task automatic expect_no_ticks(input string tag);
    vectors++;
    assert ({base_tick, obst_tick, anim_tick, sec_tick} === 4'b0000) else begin
      miscompares++;
      $error("FAIL %s ticks: observed %b expected 0000", tag,
             {base_tick, obst_tick, anim_tick, sec_tick});
    end
  endtask

  initial begin
    int s, r, rr, g, s2, r2, s3;
    reset = 1'b1; start = 1'b0; pause_toggle = 1'b0; game_over = 1'b0; level = 4'd0;
    repeat (3) step();
    expect_state("reset", PH_IDLE, 2'd0);
    expect_no_ticks("reset");
    reset = 1'b0;

    // Start at cycle 5: countdown 3-2-1, then RUN with level changes.
    run_to(5);
    s = cyc;
    r = s + 301;
    start = 1'b1;
    sched(0, s + 11, 10, r + 377);
    sched(3, s + 101, 100, r + 377);
    sched(2, r + 30, 30, r + 377);
    q_exp[1].push_back(r + 80);
    q_exp[1].push_back(r + 160);
    q_exp[1].push_back(r + 220);
    q_exp[1].push_back(r + 260);
    q_exp[1].push_back(r + 340);
    step();
    start = 1'b0;
    expect_state("cd_enter", PH_COUNTDOWN, 2'd3);
    run_to(s + 100); expect_state("cd_3_hold", PH_COUNTDOWN, 2'd3);
    run_to(s + 101); expect_state("cd_2", PH_COUNTDOWN, 2'd2);
    run_to(s + 201); expect_state("cd_1", PH_COUNTDOWN, 2'd1);
    run_to(s + 300); expect_state("cd_1_hold", PH_COUNTDOWN, 2'd1);
    run_to(r);       expect_state("run_enter", PH_RUN, 2'd0);

    run_to(r + 100); level = 4'd1;
    run_to(r + 190); level = 4'd7;
    run_to(r + 250); level = 4'd0;

    // Pause 37 clocks after the obstacle tick at r+340, hold 500 clocks.
    run_to(r + 377);
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    expect_state("paused", PH_PAUSE, 2'd0);
    run_to(r + 877);
    rr = r + 878;
    pause_toggle = 1'b1;
    g = r + 940;
    sched(0, rr + 3, 10, g);
    sched(2, r + 891, 30, g);
    sched(3, r + 901, 100, g);
    q_exp[1].push_back(rr + 43);
    step();
    pause_toggle = 1'b0;
    expect_state("resumed", PH_RUN, 2'd0);

    // Same-cycle pause_toggle and game_over: OVER wins, pending base tick dropped.
    run_to(g);
    pause_toggle = 1'b1;
    game_over = 1'b1;
    step();
    pause_toggle = 1'b0;
    game_over = 1'b0;
    expect_state("over", PH_OVER, 2'd0);
    run_to(g + 100);
    expect_state("over_hold", PH_OVER, 2'd0);

    // Restart from OVER; start/pause pulses during countdown are ignored.
    s2 = cyc;
    r2 = s2 + 301;
    start = 1'b1;
    sched(0, s2 + 11, 10, r2 + 158);
    sched(3, s2 + 101, 100, r2 + 158);
    sched(2, r2 + 30, 30, r2 + 158);
    q_exp[1].push_back(r2 + 80);
    step();
    start = 1'b0;
    expect_state("restart", PH_COUNTDOWN, 2'd3);
    run_to(s2 + 50);
    start = 1'b1; step(); start = 1'b0;
    run_to(s2 + 101); expect_state("cd2_2", PH_COUNTDOWN, 2'd2);
    run_to(s2 + 150);
    pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
    run_to(s2 + 201); expect_state("cd2_1", PH_COUNTDOWN, 2'd1);
    run_to(s2 + 250);
    start = 1'b1; pause_toggle = 1'b1; step(); start = 1'b0; pause_toggle = 1'b0;
    run_to(r2); expect_state("run2_enter", PH_RUN, 2'd0);

    // Reset one cycle before the obstacle tick at r2+160 is due.
    run_to(r2 + 159);
    reset = 1'b1;
    #1;
    expect_state("reset_mid_run", PH_IDLE, 2'd0);
    expect_no_ticks("reset_mid_run");
    repeat (5) step();
    expect_no_ticks("reset_held");
    reset = 1'b0;
    run_to(cyc + 5);

    // game_over during COUNTDOWN.
    s3 = cyc;
    start = 1'b1;
    sched(0, s3 + 11, 10, s3 + 150);
    q_exp[3].push_back(s3 + 101);
    step();
    start = 1'b0;
    run_to(s3 + 150);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    expect_state("cd_over", PH_OVER, 2'd0);
    repeat (50) step();

    for (int i = 0; i < 4; i++) begin
      vectors++;
      assert (q_exp[i].size() == 0) else begin
        miscompares++;
        $error("FAIL pending_stream%0d: observed %0d outstanding expected 0", i, q_exp[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
